// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port, with a
// pending-write scoreboard for the hazard/stall logic.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned REG_NUM_WIDTH = 5,
    parameter bit          ROUND_ROBIN   = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req0_valid_i,
    input  logic [REG_NUM_WIDTH-1:0]    req0_reg_num_i,
    input  logic [DATA_WIDTH-1:0]       req0_data_i,
    output logic                        req0_ready_o,
    input  logic                        req1_valid_i,
    input  logic [REG_NUM_WIDTH-1:0]    req1_reg_num_i,
    input  logic [DATA_WIDTH-1:0]       req1_data_i,
    output logic                        req1_ready_o,
    input  logic                        claim_i,
    input  logic [REG_NUM_WIDTH-1:0]    claim_reg_num_i,
    output logic                        wr_en_o,
    output logic [REG_NUM_WIDTH-1:0]    wr_reg_num_o,
    output logic [DATA_WIDTH-1:0]       wr_data_o,
    output logic [2**REG_NUM_WIDTH-1:0] busy_o,
    output logic                        last_grant_o
);

    localparam int unsigned NUM_REGS = 2**REG_NUM_WIDTH;

    logic                     grant0;
    logic                     grant1;
    logic                     accept;
    logic [REG_NUM_WIDTH-1:0] acc_reg_num;
    logic [DATA_WIDTH-1:0]    acc_data;
    logic                     acc_writes;
    logic [NUM_REGS-1:0]      busy_next;

    // req0 wins unless req1 also wants the port and round-robin says it is req1's turn
    always_comb begin
        grant0      = req0_valid_i && (!req1_valid_i || !ROUND_ROBIN || last_grant_o);
        grant1      = req1_valid_i && !grant0;
        accept      = grant0 || grant1;
        acc_reg_num = grant1 ? req1_reg_num_i : req0_reg_num_i;
        acc_data    = grant1 ? req1_data_i    : req0_data_i;
        acc_writes  = accept && (acc_reg_num != '0);
    end

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;

    // Clear for the write committing this cycle first, then the new claim, so a
    // coincident claim of the same register leaves it pending.
    always_comb begin
        busy_next = busy_o;
        if (wr_en_o) begin
            busy_next[wr_reg_num_o] = 1'b0;
        end
        if (claim_i && (claim_reg_num_i != '0)) begin
            busy_next[claim_reg_num_i] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_o      <= 1'b0;
            wr_reg_num_o <= '0;
            wr_data_o    <= '0;
            busy_o       <= '0;
            last_grant_o <= 1'b1;
        end else begin
            wr_en_o <= acc_writes;
            if (acc_writes) begin
                wr_reg_num_o <= acc_reg_num;
                wr_data_o    <= acc_data;
            end
            if (accept) begin
                last_grant_o <= grant1;
            end
            busy_o <= busy_next;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised and directed checks of regfile_wb_arbiter against a rule-level
// reference model (round-robin instance) plus a fixed-priority instance.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1, cl;
    logic [4:0]  n0, n1, cn;
    logic [31:0] d0, d1;
    logic        ready0, ready1, wr_en, last_grant;
    logic [4:0]  wr_num;
    logic [31:0] wr_data, busy;

    logic        f_v0, f_v1;
    logic [4:0]  f_n0, f_n1;
    logic [31:0] f_d0, f_d1;
    logic        f_ready0, f_ready1, f_wr_en, f_last;
    logic [4:0]  f_wr_num;
    logic [31:0] f_wr_data, f_busy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // reference model state
    bit          m_en;
    bit [4:0]    m_num;
    bit [31:0]   m_data;
    bit [31:0]   m_busy;
    bit          m_last;
    bit          e0, e1;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATA_WIDTH(32), .REG_NUM_WIDTH(5), .ROUND_ROBIN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid_i(v0), .req0_reg_num_i(n0), .req0_data_i(d0), .req0_ready_o(ready0),
        .req1_valid_i(v1), .req1_reg_num_i(n1), .req1_data_i(d1), .req1_ready_o(ready1),
        .claim_i(cl), .claim_reg_num_i(cn),
        .wr_en_o(wr_en), .wr_reg_num_o(wr_num), .wr_data_o(wr_data),
        .busy_o(busy), .last_grant_o(last_grant)
    );

    regfile_wb_arbiter #(.DATA_WIDTH(32), .REG_NUM_WIDTH(5), .ROUND_ROBIN(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid_i(f_v0), .req0_reg_num_i(f_n0), .req0_data_i(f_d0), .req0_ready_o(f_ready0),
        .req1_valid_i(f_v1), .req1_reg_num_i(f_n1), .req1_data_i(f_d1), .req1_ready_o(f_ready1),
        .claim_i(1'b0), .claim_reg_num_i(5'd0),
        .wr_en_o(f_wr_en), .wr_reg_num_o(f_wr_num), .wr_data_o(f_wr_data),
        .busy_o(f_busy), .last_grant_o(f_last)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en   = 1'b0;
        m_num  = '0;
        m_data = '0;
        m_busy = '0;
        m_last = 1'b1;
    endtask

    // One cycle: compare registered outputs and readies to the model, then
    // advance the model across the rising edge. Called at posedge+1.
    task automatic step();
        bit [31:0] nb;
        bit [4:0]  an;
        bit [31:0] ad;
        #1;
        check("wr_en", wr_en, m_en);
        check("wr_num", wr_num, m_num);
        check("wr_data", wr_data, m_data);
        check("busy", busy, m_busy);
        check("last_grant", last_grant, m_last);
        // both valid: the requester that did not win last time goes next
        e0 = v0 && (!v1 || m_last);
        e1 = v1 && !e0;
        check("ready0", ready0, e0);
        check("ready1", ready1, e1);
        @(posedge clk);
        nb = m_busy;
        if (m_en) nb[m_num] = 1'b0;
        if (cl && cn != 0) nb[cn] = 1'b1;
        m_busy = nb;
        if (e0 || e1) begin
            an     = e0 ? n0 : n1;
            ad     = e0 ? d0 : d1;
            m_en   = (an != 0);
            if (an != 0) begin
                m_num  = an;
                m_data = ad;
            end
            m_last = e1;
        end else begin
            m_en = 1'b0;
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        {v0, v1, cl} = '0;
        {n0, n1, cn} = '0;
        {d0, d1} = '0;
        {f_v0, f_v1} = '0;
        {f_n0, f_n1} = '0;
        {f_d0, f_d1} = '0;
        model_reset();

        #2;
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_num", wr_num, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_last", last_grant, 1);
        @(posedge clk); #1;
        rst = 1'b0;

        // reset mid-operation
        cl = 1'b1; cn = 5'd3;
        v0 = 1'b1; n0 = 5'd5; d0 = 32'hDEADBEEF;
        step();
        cl = 1'b0; v0 = 1'b0;
        check("pre_rst_wr_en", wr_en, 1);
        check("pre_rst_busy3", busy[3], 1);
        #2 rst = 1'b1;
        #1;
        check("async_wr_en", wr_en, 0);
        check("async_wr_num", wr_num, 0);
        check("async_wr_data", wr_data, 0);
        check("async_busy", busy, 0);
        check("async_last", last_grant, 1);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        v0 = 1'b1; n0 = 5'd4; d0 = 32'hA; v1 = 1'b1; n1 = 5'd6; d1 = 32'hB;
        #1 check("post_rst_ready0", ready0, 1);
        check("post_rst_ready1", ready1, 0);
        step();
        v0 = 1'b0; v1 = 1'b0;
        step();

        // single requester
        v1 = 1'b1; n1 = 5'd7; d1 = 32'h12345678;
        step();
        v1 = 1'b0;
        check("single_wr_en", wr_en, 1);
        check("single_wr_num", wr_num, 7);
        check("single_wr_data", wr_data, 32'h12345678);
        step();
        check("single_idle_wr_en", wr_en, 0);

        // contention, round robin: last winner was req1, so req0 goes first
        v0 = 1'b1; n0 = 5'd1; d0 = 32'h1; v1 = 1'b1; n1 = 5'd2; d1 = 32'h2;
        for (int i = 0; i < 4; i++) begin
            #1 check("rr_order", ready0, (i % 2) == 0);
            step();
            check("rr_wr_num", wr_num, (i % 2) == 0 ? 1 : 2);
        end
        v0 = 1'b0; v1 = 1'b0;
        step();

        // contention, fixed priority
        f_v0 = 1'b1; f_n0 = 5'd1; f_d0 = 32'h1; f_v1 = 1'b1; f_n1 = 5'd2; f_d1 = 32'h2;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("fp_ready0", f_ready0, 1);
            check("fp_ready1", f_ready1, 0);
            @(posedge clk); #1;
            check("fp_wr_num", f_wr_num, 1);
            check("fp_last", f_last, 0);
        end
        f_v0 = 1'b0;
        #1 check("fp_req1_after", f_ready1, 1);
        @(posedge clk); #1;
        f_v1 = 1'b0;
        check("fp_wr_data", f_wr_data, 32'h2);

        // register 0
        v0 = 1'b1; n0 = 5'd0; d0 = 32'hFFFFFFFF;
        #1 check("r0_ready", ready0, 1);
        step();
        v0 = 1'b0;
        check("r0_wr_en", wr_en, 0);
        check("r0_busy", busy, 0);
        check("r0_last", last_grant, 0);
        step();

        // scoreboard: claim, then write clears
        cl = 1'b1; cn = 5'd9;
        step();
        cl = 1'b0;
        check("sb_set", busy[9], 1);
        step(); step();
        v0 = 1'b1; n0 = 5'd9; d0 = 32'h99;
        step();
        v0 = 1'b0;
        check("sb_wr_en", wr_en, 1);
        check("sb_still_busy", busy[9], 1);
        step();
        check("sb_cleared", busy[9], 0);
        // write and re-claim coincide: set wins
        cl = 1'b1; cn = 5'd9;
        step();
        cl = 1'b0;
        step(); step();
        v0 = 1'b1; n0 = 5'd9; d0 = 32'h98;
        step();
        v0 = 1'b0; cl = 1'b1; cn = 5'd9;
        step();
        cl = 1'b0;
        check("sb_set_wins", busy[9], 1);
        step();

        // throughput: alternating requesters, distinct registers
        for (int i = 0; i < 16; i++) begin
            v0 = (i % 2) == 0; v1 = (i % 2) == 1;
            n0 = 5'(i + 1); n1 = 5'(i + 1);
            d0 = 32'hC000_0000 + i; d1 = 32'hC000_0000 + i;
            #1 check("tp_no_stall", ready0 | ready1, 1);
            step();
            check("tp_wr_en", wr_en, 1);
            check("tp_wr_data", wr_data, 32'hC000_0000 + i);
        end
        v0 = 1'b0; v1 = 1'b0;
        step();

        // randomised traffic with requesters holding until accepted
        for (int i = 0; i < 400; i++) begin
            cl = ($urandom_range(0, 2) == 0);
            cn = 5'($urandom);
            step();
            if (!v0 || e0) begin
                v0 = ($urandom_range(0, 2) != 0);
                n0 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                d0 = $urandom;
            end
            if (!v1 || e1) begin
                v1 = ($urandom_range(0, 2) != 0);
                n1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                d1 = $urandom;
            end
        end
        v0 = 1'b0; v1 = 1'b0; cl = 1'b0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
